// File: rtl/any1_ifetch_queue.sv
// Align-to-decode instruction FIFO; head visible one cycle after push (zero with IFQ_BYPASS_EN).
// in_rdy_o depends on registered occupancy only; flush empties the queue on the next edge.
module any1_ifetch_queue #(
  parameter int DEPTH = 4,
  parameter int AWID  = 32,
  parameter int RIDW  = 5,
  parameter int SWID  = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  input  logic                    in_v_i,
  output logic                    in_rdy_o,
  input  logic [63:0]             in_ir_i,
  input  logic [AWID-1:0]         in_ip_i,
  input  logic [AWID-1:0]         in_pip_i,
  input  logic [RIDW-1:0]         in_rid_i,
  input  logic [SWID-1:0]         in_stream_i,
  input  logic                    in_pt_i,
  output logic                    out_v_o,
  input  logic                    out_rdy_i,
  output logic [63:0]             out_ir_o,
  output logic [AWID-1:0]         out_ip_o,
  output logic [AWID-1:0]         out_pip_o,
  output logic [RIDW-1:0]         out_rid_o,
  output logic [SWID-1:0]         out_stream_o,
  output logic                    out_pt_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    afull_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 64 + 2*AWID + RIDW + SWID + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_CNT = CW'(DEPTH - 1);

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [EW-1:0] entry_in, out_ent;
  logic          occupied, push, pop, pass;

  assign entry_in = {in_ir_i, in_ip_i, in_pip_i, in_rid_i, in_stream_i, in_pt_i};
  assign occupied = (count != '0);
  assign in_rdy_o = (count != FULL_CNT);
  assign count_o  = count;
  assign afull_o  = (count >= AFULL_CNT);

`ifdef IFQ_BYPASS_EN
  logic bypass;
  // Empty queue forwards the incoming packet; it is only stored if decode stalls.
  assign bypass  = ~occupied & in_v_i & ~flush_i;
  assign out_v_o = occupied | bypass;
  assign out_ent = occupied ? mem[rd_ptr] : (bypass ? entry_in : '0);
  assign pass    = bypass & out_rdy_i;
`else
  assign out_v_o = occupied;
  assign out_ent = occupied ? mem[rd_ptr] : '0;
  assign pass    = 1'b0;
`endif

  assign {out_ir_o, out_ip_o, out_pip_o, out_rid_o, out_stream_o, out_pt_o} = out_ent;

  assign push = in_v_i & in_rdy_o & ~pass;
  assign pop  = occupied & out_rdy_i;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !flush_i && !rst_i) mem[wr_ptr] <= entry_in;
  end

endmodule
